fifo_rr_dispatcher: RTL and testbench
=====================================

// Module: fifo_rr_dispatcher
// PURPOSE
//   Moves words from the four input FIFOs (0..3) to the four output FIFOs (4..7).
//   - Round-robin arbitration picks one non-empty input FIFO per cycle.
//   - Routing: each popped word goes to the output FIFO named by its two destination MSBs.
//   - Flow control: all pops stop while any output FIFO reports almost-full.
//   Sits between the input FIFO bank and the output FIFO bank in the complete module.
// PARAMETERS
//   DATA_WIDTH  10  word width; bits [DATA_WIDTH-1:DATA_WIDTH-2] = destination (0..3 -> FIFO 4..7)
// PORTS
//   clk              in   1           single clock, all logic on posedge
//   reset            in   1           asynchronous, active-low; 0 forces reset state immediately
//   init             in   1           sync; 1 holds block in INIT (no new pops)
//   in_empty         in   4           empty flags of input FIFOs 0..3
//   in_data0..3      in   DATA_WIDTH  registered read data of input FIFOs 0..3
//   out_almost_full  in   4           almost-full flags of output FIFOs 4..7
//   pop_in           out  4           one-hot pop to input FIFOs 0..3
//   push_out         out  4           one-hot push to output FIFOs 4..7
//   data_out         out  DATA_WIDTH  word written with push_out
//   grant_idx        out  2           index of the most recently granted input FIFO
//   idle             out  1           1 = IDLE state and pipeline empty
// BEHAVIOUR
//   Reset (reset=0):
//   - pop_in=0, push_out=0, data_out=0, grant_idx=0, idle=0, state=INIT.
//   - RR pointer=3, so the first grant goes to FIFO 0.
//   - In-flight words are discarded.
//   FSM:
//   - INIT: entered on reset release. Exits on the first cycle with init=0:
//     to IDLE if all in_empty=1, else to ACTIVE.
//   - IDLE: exits when any in_empty=0 (to ACTIVE).
//   - ACTIVE: returns to IDLE when all in_empty=1 and the pipeline is empty.
//   - init=1 in any state -> INIT next cycle.
//   - Words already popped always complete their push, including across INIT.
//   Grant (pop_in, combinational, cycle N):
//   - Only in ACTIVE, and only when out_almost_full==0.
//   - Candidate set: FIFOs with in_empty=0.
//   - Grant = first candidate after the RR pointer, searching upward, wrapping 3->0.
//   - At most one pop bit per cycle.
//   - On grant: RR pointer <= granted index; grant_idx <= granted index (registered).
//   - Back-to-back grants are allowed; a lone non-empty FIFO is granted every cycle.
//   Datapath:
//   - Cycle N+1: in_data[grant] is valid; it is captured with its destination.
//   - Cycle N+2: push_out[dest]=1 for one cycle, data_out=word (registered).
//   - Pop-to-push latency is 2 cycles; throughput is 1 word/cycle.
//   - push_out=0 in any cycle with no word exiting; data_out holds its last value.
//   Boundaries:
//   - Almost-full rising at N stalls the pop at N. Up to 2 earlier words may still land.
//     Output FIFO almost-full thresholds must leave >=2 free slots.
//   - Empty FIFOs are never popped.
//   - in_empty and out_almost_full changing in the same cycle use the current-cycle values.
//   - Two consecutive words to the same destination give consecutive pushes.
//   - idle=1 only when state=IDLE and no word is in the 2-stage pipeline.
//   - idle is registered and updates the cycle after the state change.
// TESTING
//   1. Reset low mid-traffic -> all outputs 0 immediately. After release with init=0
//      and FIFO 2 non-empty: INIT -> ACTIVE, first pop_in=4'b0100.
//   2. All four FIFOs non-empty, no almost-full -> pop_in sequence 0001,0010,0100,1000,0001.
//      push_out follows 2 cycles later.
//   3. in_data1=10'b11_0000_0101 popped at N -> push_out=4'b1000, data_out=10'h305 at N+2.
//   4. out_almost_full=4'b0010 while FIFOs are non-empty -> pop_in=0 during the stall.
//      Clearing it -> grant resumes at the next RR index; at most 2 pushes land after the rise.
//   5. init=1 pulsed during traffic -> no pops while init=1, pending pushes complete,
//      RR order continues after release.
//   6. FIFOs drain to empty -> pop_in=0, idle=1 three cycles after the last pop.
//      New non-empty -> idle=0, pop resumes.

Source files
------------

// File: rtl/fifo_rr_dispatcher.sv
// fifo_rr_dispatcher: round-robin mover from input FIFOs 0..3
// to output FIFOs 4..7, routed by the two destination MSBs.
module fifo_rr_dispatcher #(
  parameter int DATA_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic [3:0]            in_empty,
  input  logic [DATA_WIDTH-1:0] in_data0,
  input  logic [DATA_WIDTH-1:0] in_data1,
  input  logic [DATA_WIDTH-1:0] in_data2,
  input  logic [DATA_WIDTH-1:0] in_data3,
  input  logic [3:0]            out_almost_full,
  output logic [3:0]            pop_in,
  output logic [3:0]            push_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [1:0]            grant_idx,
  output logic                  idle
);

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_ACTIVE
  } state_e;

  state_e                state_q;
  logic                  idle_q;
  logic [1:0]            rr_q;
  logic [1:0]            gidx_q;
  logic                  s1_v_q;
  logic [1:0]            s1_idx_q;
  logic [3:0]            push_q;
  logic [3:0]            push_d;
  logic [DATA_WIDTH-1:0] dout_q;
  logic [DATA_WIDTH-1:0] dout_d;
  logic [DATA_WIDTH-1:0] sel_w;
  logic                  gnt_v;
  logic [1:0]            gnt_idx;
  logic [1:0]            cand;
  logic [3:0]            gnt_oh;
  logic                  all_empty;

  assign all_empty = &in_empty;

  // Round-robin search upward from the pointer, gated by state and back-pressure
  always_comb begin
    gnt_v   = 1'b0;
    gnt_idx = rr_q;
    cand    = rr_q;
    gnt_oh  = '0;
    if (state_q == S_ACTIVE && !init && out_almost_full == 4'b0) begin
      for (int k = 1; k <= 4; k++) begin
        cand = rr_q + 2'(k);
        if (!gnt_v && !in_empty[cand]) begin
          gnt_v   = 1'b1;
          gnt_idx = cand;
        end
      end
    end
    if (gnt_v) gnt_oh[gnt_idx] = 1'b1;
  end

  // Pick the read data of the FIFO popped last cycle
  always_comb begin
    sel_w = in_data0;
    unique case (s1_idx_q)
      2'd0: sel_w = in_data0;
      2'd1: sel_w = in_data1;
      2'd2: sel_w = in_data2;
      2'd3: sel_w = in_data3;
    endcase
  end

  // Route the captured word to its destination; data_out holds when idle
  always_comb begin
    push_d = '0;
    dout_d = dout_q;
    if (s1_v_q) begin
      push_d[sel_w[DATA_WIDTH-1:DATA_WIDTH-2]] = 1'b1;
      dout_d = sel_w;
    end
  end

  // Control FSM; idle reflects the state and pipeline after this edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_INIT;
      idle_q  <= 1'b0;
    end else if (init) begin
      state_q <= S_INIT;
      idle_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_INIT: begin
          if (all_empty) begin
            state_q <= S_IDLE;
            idle_q  <= !s1_v_q;
          end else begin
            state_q <= S_ACTIVE;
            idle_q  <= 1'b0;
          end
        end
        S_IDLE: begin
          if (!all_empty) begin
            state_q <= S_ACTIVE;
            idle_q  <= 1'b0;
          end else begin
            idle_q  <= !s1_v_q;
          end
        end
        S_ACTIVE: begin
          if (all_empty && !s1_v_q && !gnt_v) begin
            state_q <= S_IDLE;
            idle_q  <= 1'b1;
          end else begin
            idle_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_INIT;
          idle_q  <= 1'b0;
        end
      endcase
    end
  end

  // Grant bookkeeping and the two-stage pop-to-push pipeline
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_q     <= 2'd3;
      gidx_q   <= 2'd0;
      s1_v_q   <= 1'b0;
      s1_idx_q <= 2'd0;
      push_q   <= '0;
      dout_q   <= '0;
    end else begin
      if (gnt_v) begin
        rr_q   <= gnt_idx;
        gidx_q <= gnt_idx;
      end
      s1_v_q   <= gnt_v;
      s1_idx_q <= gnt_idx;
      push_q   <= push_d;
      dout_q   <= dout_d;
    end
  end

  assign pop_in    = gnt_oh;
  assign push_out  = push_q;
  assign data_out  = dout_q;
  assign grant_idx = gidx_q;
  assign idle      = idle_q;

endmodule

// File: tb/tb_fifo_rr_dispatcher.sv
// tb_fifo_rr_dispatcher: directed stimulus with an input FIFO model
// and a push scoreboard checked by an independent monitor.
module tb_fifo_rr_dispatcher;
  localparam int DW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          init = 1'b0;
  logic [3:0]    in_empty = 4'hF;
  logic [3:0]    af = 4'h0;
  logic [DW-1:0] din [4] = '{default: '0};
  logic [3:0]    pop_in;
  logic [3:0]    push_out;
  logic [DW-1:0] data_out;
  logic [1:0]    grant_idx;
  logic          idle;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [3:0]    pv = 4'h0;
  logic [DW-1:0] mw;
  logic [DW-1:0] last_w = '0;
  logic [1:0]    gi_m = 2'd0;
  logic [DW-1:0] fq [4][$];

  typedef struct {
    int            arr;
    logic [DW-1:0] w;
  } exp_t;
  exp_t exp_q [$];
  exp_t e;

  fifo_rr_dispatcher #(.DATA_WIDTH(DW)) dut (
    .clk(clk),
    .reset(rst_n),
    .init(init),
    .in_empty(in_empty),
    .in_data0(din[0]),
    .in_data1(din[1]),
    .in_data2(din[2]),
    .in_data3(din[3]),
    .out_almost_full(af),
    .pop_in(pop_in),
    .push_out(push_out),
    .data_out(data_out),
    .grant_idx(grant_idx),
    .idle(idle)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d act=%0h exp=%0h", nm, cyc, act, exp);
    end
  endfunction

  function automatic logic [1:0] oh2i(input logic [3:0] oh);
    logic [1:0] r;
    r = 2'd0;
    unique case (1'b1)
      oh[0]: r = 2'd0;
      oh[1]: r = 2'd1;
      oh[2]: r = 2'd2;
      oh[3]: r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  function automatic void ld(input int i, input logic [DW-1:0] w);
    fq[i].push_back(w);
  endfunction

  // Input FIFO bank model: registered read data, flags after the edge
  always @(posedge clk) begin
    cyc++;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (pv[i]) begin
        chk("pop_nonempty", 32'(fq[i].size() != 0), 32'd1);
        if (fq[i].size() != 0) begin
          mw = fq[i].pop_front();
          din[i] = mw;
          exp_q.push_back('{cyc + 1, mw});
        end
      end
    end
    for (int i = 0; i < 4; i++) in_empty[i] = (fq[i].size() == 0);
  end

  // Monitor: sample pops, compare every push against the scoreboard
  always @(negedge clk) begin
    pv = pop_in;
    if (rst_n) begin
      if (push_out != 4'h0) begin
        if (exp_q.size() == 0) begin
          chk("push_unexpected", 32'(push_out), 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk("push_dest", 32'(push_out), 32'(4'b1 << e.w[DW-1:DW-2]));
          chk("data_out", 32'(data_out), 32'(e.w));
          chk("push_cycle", 32'(cyc), 32'(e.arr));
          last_w = e.w;
        end
      end else if (exp_q.size() != 0 && exp_q[0].arr <= cyc) begin
        e = exp_q.pop_front();
        chk("push_missing", 32'(push_out), 32'(4'b1 << e.w[DW-1:DW-2]));
      end
    end
  end

  task automatic step(input logic [3:0] ep, input int eidle = -1);
    @(negedge clk);
    #1;
    chk("pop_in", 32'(pop_in), 32'(ep));
    chk("grant_idx", 32'(grant_idx), 32'(gi_m));
    if (eidle >= 0) chk("idle", 32'(idle), 32'(eidle[0]));
    if (ep != 4'h0) gi_m = oh2i(ep);
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("rst_pop", 32'(pop_in), 32'h0);
    chk("rst_push", 32'(push_out), 32'h0);
    chk("rst_data", 32'(data_out), 32'h0);
    chk("rst_gidx", 32'(grant_idx), 32'h0);
    chk("rst_idle", 32'(idle), 32'h0);
    rst_n = 1'b1;
    step(4'h0);
    step(4'h0);
    step(4'h0, 1);

    ld(0, 10'h0A1); ld(0, 10'h1B2);
    ld(1, 10'h305); ld(1, 10'h244);
    ld(2, 10'h2C3); ld(2, 10'h0D4);
    ld(3, 10'h1E5); ld(3, 10'h3F6);
    step(4'h0, 1);
    step(4'h0, 1);
    step(4'b0001, 0);
    step(4'b0010);
    step(4'b0100);
    step(4'b1000);
    step(4'b0001);
    step(4'b0010);
    step(4'b0100);
    step(4'b1000);
    step(4'h0, 0);
    step(4'h0, 0);
    step(4'h0, 1);
    chk("data_hold", 32'(data_out), 32'h3F6);

    ld(0, 10'h011); ld(0, 10'h112);
    ld(1, 10'h213); ld(1, 10'h314);
    ld(2, 10'h015); ld(2, 10'h116);
    ld(3, 10'h217); ld(3, 10'h318);
    step(4'h0, 1);
    step(4'h0, 1);
    step(4'b0001, 0);
    step(4'b0010);
    af = 4'b0010;
    step(4'h0);
    step(4'h0);
    af = 4'b0000;
    step(4'b0100);
    step(4'b1000);
    step(4'b0001);
    step(4'b0010);
    step(4'b0100);
    step(4'b1000);
    step(4'h0);
    step(4'h0, 0);
    step(4'h0, 1);

    ld(0, 10'h121); ld(0, 10'h222);
    ld(1, 10'h323); ld(1, 10'h024);
    ld(2, 10'h125); ld(2, 10'h226);
    ld(3, 10'h327); ld(3, 10'h028);
    step(4'h0, 1);
    step(4'h0, 1);
    step(4'b0001, 0);
    step(4'b0010);
    init = 1'b1;
    step(4'h0);
    step(4'h0, 0);
    init = 1'b0;
    step(4'h0);
    step(4'b0100);
    step(4'b1000);
    step(4'b0001);
    step(4'b0010);
    step(4'b0100);
    step(4'b1000);
    step(4'h0);
    step(4'h0, 0);
    step(4'h0, 1);

    ld(1, 10'h1A0); ld(1, 10'h1A1); ld(1, 10'h1A2);
    step(4'h0, 1);
    step(4'h0, 1);
    step(4'b0010, 0);
    step(4'b0010);
    step(4'b0010);
    step(4'h0);
    step(4'h0, 0);
    step(4'h0, 1);

    ld(0, 10'h0F0); ld(2, 10'h2F2); ld(3, 10'h3F1);
    step(4'h0, 1);
    step(4'h0, 1);
    step(4'b0100, 0);
    step(4'b1000);
    rst_n = 1'b0;
    #1;
    chk("arst_pop", 32'(pop_in), 32'h0);
    chk("arst_push", 32'(push_out), 32'h0);
    chk("arst_data", 32'(data_out), 32'h0);
    chk("arst_gidx", 32'(grant_idx), 32'h0);
    chk("arst_idle", 32'(idle), 32'h0);
    exp_q.delete();
    for (int i = 0; i < 4; i++) fq[i].delete();
    gi_m = 2'd0;
    @(posedge clk);
    #2;
    ld(2, 10'h2AB);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step(4'h0);
    step(4'b0100);
    step(4'h0);
    step(4'h0, 0);
    step(4'h0, 1);

    chk("sb_drained", 32'(exp_q.size()), 32'h0);
    for (int i = 0; i < 4; i++) chk("fifo_drained", 32'(fq[i].size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
